// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch stage of the single-cycle core.
package cpu_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // One prefetch buffer entry: the fetched word and the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory, the core and the
// redirect source. The master side is the fetch unit itself.
interface fetch_unit_if;

  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [cpu_pkg::XLEN-1:0] mem_req_addr;
  logic                     mem_rsp_valid;
  logic [cpu_pkg::XLEN-1:0] mem_rsp_data;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [cpu_pkg::XLEN-1:0] instr;
  logic [cpu_pkg::XLEN-1:0] instr_pc;
  logic                     redirect_valid;
  logic [cpu_pkg::XLEN-1:0] redirect_pc;
  logic                     err_rsp;

  modport master (
    output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc, err_rsp,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc, err_rsp,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch buffer holding fetched words with their PCs. Pointers carry an
// extra wrap bit so count distinguishes full from empty. Flush wins over
// push and pop; the fetch unit's credit scheme guarantees push never
// lands on a full buffer.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [AW:0]  count,
  output logic         empty
);

  fetch_entry_t mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update: flush resets both, otherwise advance on push / legal pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push)           wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop && !empty)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches to a variable
// latency memory, buffers returned words with their PCs and hands them to
// the core. A redirect restarts fetch and discards every response still in
// flight by counting them into drop_cnt.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            err_rsp_q, err_rsp_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  fetch_entry_t    fifo_din;
  fetch_entry_t    fifo_dout;
  logic            fifo_push;
  logic            fifo_pop;

  logic [CW:0]     credit_used;
  logic            req_valid;
  logic            req_xfer;
  logic            rsp_ok;

  // Handshake decode: request credit, which responses count, push/pop.
  always_comb begin
    credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    req_valid   = !rst && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
    req_xfer    = req_valid && bus.mem_req_ready;
    rsp_ok      = bus.mem_rsp_valid && (outstanding_q != '0);
    fifo_push   = rsp_ok && (drop_cnt_q == '0) && !bus.redirect_valid;
    fifo_pop    = !fifo_empty && bus.instr_ready && !bus.redirect_valid;
    fifo_din    = '{pc: rsp_pc_q, instr: bus.mem_rsp_data};
  end

  // Next-state for PCs and counters; redirect overrides the PC/drop updates.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_xfer) - CW'(rsp_ok);
    err_rsp_d     = err_rsp_q | (bus.mem_rsp_valid && (outstanding_q == '0));
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc_d   = {bus.redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt_d = outstanding_q - CW'(rsp_ok);
    end else begin
      if (req_xfer) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_ok) begin
        if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - 1'b1;
        else                  rsp_pc_d   = rsp_pc_q + 32'd4;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      err_rsp_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      err_rsp_q     <= err_rsp_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (bus.redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.instr_valid   = !fifo_empty;
  assign bus.instr         = fifo_empty ? '0 : fifo_dout.instr;
  assign bus.instr_pc      = fifo_empty ? '0 : fifo_dout.pc;
  assign bus.err_rsp       = err_rsp_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the single-cycle core's decode/execute datapath. It generates sequential PCs from 32'h00400000 and issues requests to a variable-latency instruction memory. Returned words are buffered with their PCs in a small prefetch FIFO and handed to the core over a valid/ready handshake. A taken branch or jump redirects the fetch PC, flushes the buffer and discards stale in-flight responses.

Parameters:
DEPTH, 4, prefetch FIFO entries and maximum requests in flight; must be a power of 2 and at least 2.
RESET_PC, 32'h00400000, first fetch address after reset (text segment).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
mem_req_valid  output  1  fetch request to instruction memory.
mem_req_ready  input  1  memory accepts the request this cycle.
mem_req_addr  output  32  word-aligned fetch address.
mem_rsp_valid  input  1  read data returned; responses arrive in order; no backpressure.
mem_rsp_data  input  32  instruction word.
instr_valid  output  1  instr/instr_pc hold a valid entry.
instr_ready  input  1  core consumes the entry.
instr  output  32  instruction word at the FIFO head.
instr_pc  output  32  PC of instr.
redirect_valid  input  1  flush and restart fetch.
redirect_pc  input  32  new fetch PC; bits [1:0] forced to 0.
err_rsp  output  1  sticky flag: response received with zero outstanding requests.

Behaviour:
- Reset (async, any time, including mid-transfer): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, err_rsp=0. Outputs: mem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
- Request issue: mem_req_valid = !redirect_valid && (outstanding + fifo_count < DEPTH). mem_req_addr = fetch_pc.
  - Transfer occurs only on valid&&ready. Valid may drop and addr may change without a transfer.
  - On transfer: fetch_pc += 4 (32-bit wrap) and outstanding increments.
- Response: every mem_rsp_valid decrements outstanding.
  - If drop_cnt>0: decrement drop_cnt and discard the data.
  - Otherwise: push {rsp_pc, mem_rsp_data} into the FIFO and rsp_pc += 4.
  - If mem_rsp_valid arrives with outstanding==0: ignore it and set err_rsp=1; it stays set until rst.
- Output: instr_valid = FIFO non-empty. instr/instr_pc show the head entry. Pop on instr_valid&&instr_ready.
  - Latency: response accepted at edge N, instr_valid=1 after edge N; no combinational path from mem_rsp to instr.
  - Best case is one instruction per cycle with a 1-cycle memory.
- Credit rule: outstanding + fifo_count ≤ DEPTH, so a push can never hit a full FIFO.
  - Simultaneous push and pop at fifo_count==DEPTH-1 is legal.
  - Simultaneous push and pop on an empty FIFO goes through the FIFO; there is no bypass.
- Redirect (cycle R), with precedence over everything else:
  - FIFO cleared; any pop in cycle R is ignored.
  - mem_req_valid=0 in cycle R.
  - fetch_pc=rsp_pc=redirect_pc&~3.
  - drop_cnt = outstanding - mem_rsp_valid; a response arriving in R is itself discarded.
  - outstanding keeps its normal update.
  - From R+1, fetching resumes at the new PC. The first new instr_valid is never earlier than R+2.
- Back-to-back redirects: each one recomputes drop_cnt from the current outstanding, so no stale word ever reaches instr.
- Counters: outstanding and drop_cnt are $clog2(DEPTH)+1 bits wide; fifo pointers are $clog2(DEPTH)+1 bits wide with a wrap bit.

Decomposition:
- Package cpu_pkg holds: XLEN=32, RESET_PC_DEFAULT=32'h00400000, and typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
- Sub-module fetch_fifo: parameter DEPTH, ports clk/rst/push/pop/flush/din/dout/count/empty, storing fetch_entry_t. The flush input clears the pointers.

Test Plan:
1. Reset then 1-cycle memory with ready=1 and instr_ready=1 → mem_req_addr goes 00400000, 00400004, ...; instr_pc matches in order and instr_valid stays 1 every cycle after fill.
2. instr_ready=0 with DEPTH=4 → exactly 4 transfers, then mem_req_valid=0; FIFO holds 00400000..0040000C; releasing instr_ready resumes requests.
3. 3-cycle latency memory with 3 requests in flight, redirect_pc=00400040 → the 3 stale responses are dropped; the next instr_pc is 00400040.
4. Redirect in the same cycle as mem_rsp_valid and instr_ready → that response is dropped, drop_cnt=outstanding-1, and no pop of the stale head is observed.
5. rst asserted mid-stream (asynchronously, between edges) → instr_valid and mem_req_valid go 0 immediately; after release, the first mem_req_addr is 00400000.
6. Spurious mem_rsp_valid with outstanding=0 → err_rsp=1 and held; FIFO is unchanged.
